terrain_store: RTL

TERRAIN_STORE -- requirements
Module: terrain_store

---
 rtl/terrain_pkg.sv | 25 ++
 rtl/terrain_store_if.sv | 27 ++
 rtl/terrain_store_clr_fifo.sv | 53 +++++
 rtl/terrain_store.sv | 136 +++++++++++++
 4 files changed

// File: rtl/terrain_pkg.sv
// Shared constants, state encodings and the clear-request record for the
// destructible terrain column store.
package terrain_pkg;

  localparam int NUM_COLS = 640;
  localparam int COL_BITS = 512;

  localparam logic [9:0] NUM_COLS_X = 10'd640;
  localparam logic [9:0] LAST_COL_X = 10'd639;

  typedef enum logic {INIT, RUN} top_state_e;

  typedef enum logic [1:0] {C_IDLE, C_RD, C_WR} clr_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } clr_req_t;

  // Flat ground: every row at or below ground_y is solid.
  function automatic logic [COL_BITS-1:0] ground_col(input logic [9:0] ground_y);
    return {COL_BITS{1'b1}} << ground_y;
  endfunction

endpackage

// File: rtl/terrain_store_if.sv
// Draw-side read port, bomb write-back port and pixel-clear request port of
// the terrain store.
interface terrain_store_if;
  import terrain_pkg::*;

  logic [9:0]          rd_x;
  logic [COL_BITS-1:0] terrain_data;
  logic                wb_en;
  logic [9:0]          wb_x;
  logic [COL_BITS-1:0] wb_data;
  logic                clr_valid;
  logic [9:0]          clr_x;
  logic [8:0]          clr_y;
  logic                clr_ready;
  logic                init_done;

  modport slave (
    input  rd_x, wb_en, wb_x, wb_data, clr_valid, clr_x, clr_y,
    output terrain_data, clr_ready, init_done
  );

  modport master (
    output rd_x, wb_en, wb_x, wb_data, clr_valid, clr_x, clr_y,
    input  terrain_data, clr_ready, init_done
  );

endinterface

// File: rtl/terrain_store_clr_fifo.sv
// Small circular queue of pending pixel-clear requests; a push is still taken
// when full as long as a pop happens on the same edge.
module clr_fifo
  import terrain_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  clr_req_t din_i,
  output logic     full_o,
  input  logic     pop_i,
  output clr_req_t dout_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  clr_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/terrain_store.sv
// 640 x 512-bit terrain column RAM: flat-ground fill after reset, registered
// column reads, whole-column write-back and a queued single-pixel clear engine.
module terrain_store
  import terrain_pkg::*;
#(
  parameter logic [9:0] GROUND_Y   = 10'd360,
  parameter int         FIFO_DEPTH = 8
) (
  input logic            clk,
  input logic            reset,
  terrain_store_if.slave bus
);

  localparam logic [COL_BITS-1:0] GROUND_COL = ground_col(GROUND_Y);

  logic [COL_BITS-1:0] col_mem [NUM_COLS];

  top_state_e          state_q;
  logic [9:0]          fill_q;
  logic                init_done_q;
  clr_state_e          cstate_q;
  clr_req_t            req_q;
  logic [COL_BITS-1:0] col_q;
  logic [COL_BITS-1:0] rd_data_q;

  logic                run;
  logic                wb_hit;
  logic                wb_hits_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  clr_req_t            fifo_din;
  clr_req_t            fifo_dout;

  logic                wr_en;
  logic [9:0]          wr_addr;
  logic [COL_BITS-1:0] wr_data;

  assign run         = (state_q == RUN);
  assign wb_hit      = run && bus.wb_en && (bus.wb_x < NUM_COLS_X);
  assign wb_hits_req = bus.wb_en && (bus.wb_x == req_q.x);
  assign fifo_din    = '{x: bus.clr_x, y: bus.clr_y};
  // Any write-back strobe holds the engine off the RAM, including the pop.
  assign fifo_pop    = run && (cstate_q == C_IDLE) && !bus.wb_en;

  assign bus.clr_ready    = !fifo_full && run;
  assign bus.init_done    = init_done_q;
  assign bus.terrain_data = rd_data_q;

  clr_fifo #(.DEPTH(FIFO_DEPTH)) u_clr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.clr_valid && bus.clr_ready),
    .din_i   (fifo_din),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty)
  );

  // Single RAM write port: fill, then write-back, then the clear engine.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = fill_q;
    wr_data = GROUND_COL;
    if (!run) begin
      wr_en = 1'b1;
    end else if (wb_hit) begin
      wr_en   = 1'b1;
      wr_addr = bus.wb_x;
      wr_data = bus.wb_data;
    end else if ((cstate_q == C_WR) && !bus.wb_en) begin
      wr_en   = 1'b1;
      wr_addr = req_q.x;
      wr_data = col_q & ~({{(COL_BITS-1){1'b0}}, 1'b1} << req_q.y);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      col_mem[wr_addr] <= wr_data;
    end
  end

  // Draw read port, write-first on a same-column write.
  always_ff @(posedge clk) begin
    if (reset || !run || (bus.rd_x >= NUM_COLS_X)) begin
      rd_data_q <= '0;
    end else if (wr_en && (wr_addr == bus.rd_x)) begin
      rd_data_q <= wr_data;
    end else begin
      rd_data_q <= col_mem[bus.rd_x];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      fill_q      <= '0;
      init_done_q <= 1'b0;
      cstate_q    <= C_IDLE;
      req_q       <= '0;
      col_q       <= '0;
    end else begin
      if (state_q == INIT) begin
        if (fill_q == LAST_COL_X) begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end else begin
          fill_q <= fill_q + 1'b1;
        end
      end
      case (cstate_q)
        C_IDLE: begin
          if (fifo_pop && !fifo_empty) begin
            req_q <= fifo_dout;
            // Off-screen requests are dropped here so the RAM never sees them.
            if (fifo_dout.x < NUM_COLS_X) cstate_q <= C_RD;
          end
        end
        C_RD: begin
          if (!wb_hits_req) begin
            col_q    <= col_mem[req_q.x];
            cstate_q <= C_WR;
          end
        end
        C_WR: begin
          if (wb_hits_req)      cstate_q <= C_RD;
          else if (!bus.wb_en)  cstate_q <= C_IDLE;
        end
        default: cstate_q <= C_IDLE;
      endcase
    end
  end

endmodule
